// File: rtl/axi_rd_stride_master.sv
// AXI4 read master that turns one strided command into cmd_num equally spaced AR bursts
// and streams the returned R beats to the LSU through a small in-order FIFO.
module axi_rd_stride_master #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 4,
    parameter int OUTSTD     = 16,
    parameter int RBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_stride,
    input  logic [CNT_WIDTH-1:0]  cmd_num,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    output logic                  cmd_done,
    output logic                  cmd_err,
    output logic [ID_WIDTH-1:0]   ARID,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic [3:0]            ARREGION,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [ID_WIDTH-1:0]   RID,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic                  lsu_rvld,
    input  logic                  lsu_rrdy,
    output logic [ID_WIDTH-1:0]   lsu_rid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic                  lsu_rlast
);

    localparam int OW = $clog2(OUTSTD + 1);
    localparam int PW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
    localparam int FW = PW + 1;
    localparam logic [OW-1:0] OUTSTD_MAX = OW'(OUTSTD);
    localparam logic [FW-1:0] RBUF_FULL  = FW'(RBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } rbeat_t;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   issued_q, issued_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [ADDR_WIDTH-1:0]  stride_q, stride_d;
    logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [ID_WIDTH-1:0]    arid_q, arid_d;
    logic [7:0]             arlen_q, arlen_d;
    logic [2:0]             arsize_q, arsize_d;
    logic [1:0]             arburst_q, arburst_d;
    logic [OW-1:0]          outstd_q, outstd_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   done_err_q, done_err_d;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]          cnt_q, cnt_d;
    rbeat_t                 mem_q [RBUF_DEPTH];
    rbeat_t                 head;

    logic arvalid, ar_hs, rready, r_hs, r_last_hs, push, pop;

    assign arvalid   = (state_q == ISSUE) && (outstd_q < OUTSTD_MAX);
    assign ar_hs     = arvalid && ARREADY;
    // RREADY follows FIFO space only; beats are accepted in any state.
    assign rready    = !rst && (cnt_q != RBUF_FULL);
    assign r_hs      = RVALID && rready;
    assign r_last_hs = r_hs && RLAST && (outstd_q != '0);
    assign push      = r_hs;
    assign pop       = lsu_rvld && lsu_rrdy;
    assign cnt_d     = cnt_q + FW'(push) - FW'(pop);

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        issued_d   = issued_q;
        num_d      = num_q;
        stride_d   = stride_q;
        araddr_d   = araddr_q;
        arid_d     = arid_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        arburst_d  = arburst_q;
        err_d      = err_q;
        done_d     = 1'b0;
        done_err_d = 1'b0;
        outstd_d   = outstd_q + OW'(ar_hs) - OW'(r_last_hs);

        // A beat with no burst in flight is stray and poisons the command like SLVERR/DECERR.
        if (r_hs && (RRESP[1] || (outstd_q == '0))) err_d = 1'b1;

        if (ar_hs) begin
            issued_d = issued_q + 1'b1;
            araddr_d = araddr_q + stride_q;
            arid_d   = arid_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    num_d     = cmd_num;
                    stride_d  = cmd_stride;
                    araddr_d  = cmd_addr;
                    arlen_d   = cmd_len;
                    arsize_d  = cmd_size;
                    arburst_d = cmd_burst;
                    issued_d  = '0;
                    err_d     = 1'b0;
                    if (cmd_num == '0) done_d = 1'b1;
                    else               state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ar_hs && (issued_q == num_q - 1'b1)) state_d = DRAIN;
            end
            DRAIN: begin
                if ((outstd_q == '0) && (cnt_q == '0)) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    done_err_d = err_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            num_q      <= '0;
            stride_q   <= '0;
            araddr_q   <= '0;
            arid_q     <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            outstd_q   <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q    <= state_d;
            issued_q   <= issued_d;
            num_q      <= num_d;
            stride_q   <= stride_d;
            araddr_q   <= araddr_d;
            arid_q     <= arid_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            arburst_q  <= arburst_d;
            outstd_q   <= outstd_d;
            err_q      <= err_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
            cnt_q      <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {RID, RDATA, RRESP, RLAST};
    end

    assign lsu_rvld  = (cnt_q != '0);
    assign head      = lsu_rvld ? mem_q[rd_ptr_q] : '0;
    assign lsu_rid   = head.id;
    assign lsu_rdata = head.data;
    assign lsu_rresp = head.resp;
    assign lsu_rlast = head.last;

    assign cmd_rdy  = (state_q == IDLE);
    assign cmd_done = done_q;
    assign cmd_err  = done_err_q;
    assign ARVALID  = arvalid;
    assign ARID     = arid_q;
    assign ARADDR   = araddr_q;
    assign ARLEN    = arlen_q;
    assign ARSIZE   = arsize_q;
    assign ARBURST  = arburst_q;
    assign ARREGION = 4'h0;
    assign RREADY   = rready;

endmodule
